// File: rtl/id_seg_reg_param.sv
// ============================================================================
// Module   : id_seg_reg_param
// Purpose  : IF-ID segment register with an embedded synchronous dual-port
//            instruction memory. Port A is the fetch port whose registered
//            read feeds the ID stage, with stall and flush applied on the
//            output path. Port B is a byte-writable, read-first debug port.
// Ports    : clk, rst              - clock, synchronous active-high reset
//            en, clear             - advance enable (0 = stall), ID flush
//            A  -> RD              - fetch byte address / instruction to ID
//            A2, WD2, WE2 -> RD2   - debug address, data, byte enables, read
//            PCF -> PCD, ValidD    - IF PC / ID PC and real-instruction flag
//            StallCnt, FlushCnt    - performance counters (optional)
// Options  : define IDSEG_PERF_CNT_EN to add the stall/flush counters.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module id_seg_reg_param #(
    parameter int               XLEN        = 32,
    parameter int               DEPTH_LOG2  = 12,
    parameter logic [XLEN-1:0]  CLEAR_VALUE = 32'h00000013,
    parameter string            INIT_FILE   = ""
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                clear,
    input  logic                en,
    input  logic [XLEN-1:0]     A,
    output logic [XLEN-1:0]     RD,
    input  logic [XLEN-1:0]     A2,
    input  logic [XLEN-1:0]     WD2,
    input  logic [XLEN/8-1:0]   WE2,
    output logic [XLEN-1:0]     RD2,
    input  logic [XLEN-1:0]     PCF,
    output logic [XLEN-1:0]     PCD,
    output logic                ValidD
`ifdef IDSEG_PERF_CNT_EN
    ,
    output logic [31:0]         StallCnt,
    output logic [31:0]         FlushCnt
`endif
);

    localparam int c_DEPTH  = 1 << DEPTH_LOG2;
    localparam int c_NBYTES = XLEN / 8;

    // ------------------------------------------------------------------------
    // Memory array (contents are never reset)
    // ------------------------------------------------------------------------
    logic [XLEN-1:0]        r_mem [c_DEPTH];
    logic [DEPTH_LOG2-1:0]  w_idx_a;
    logic [DEPTH_LOG2-1:0]  w_idx_b;
    logic [XLEN-1:0]        r_rd_raw;
    logic [XLEN-1:0]        r_rd2;

    // Byte offset and bits above the depth are dropped: addresses wrap.
    assign w_idx_a = A[DEPTH_LOG2+1:2];
    assign w_idx_b = A2[DEPTH_LOG2+1:2];

    logic [2*(XLEN-DEPTH_LOG2)-1:0] w_unused_addr_bits;
    assign w_unused_addr_bits = {A[XLEN-1:DEPTH_LOG2+2], A[1:0],
                                 A2[XLEN-1:DEPTH_LOG2+2], A2[1:0]};

    // Both reads sample the array before this edge's writes land, so port B
    // is read-first and a same-word fetch on port A also sees the old word.
    always_ff @(posedge clk) begin
        r_rd_raw <= r_mem[w_idx_a];
        r_rd2    <= r_mem[w_idx_b];
        for (int i = 0; i < c_NBYTES; i++) begin
            if (WE2[i]) begin
                r_mem[w_idx_b][i*8 +: 8] <= WD2[i*8 +: 8];
            end
        end
    end

    assign RD2 = r_rd2;

    // ------------------------------------------------------------------------
    // Output-path control: the stall/flush decision is registered alongside
    // the memory read so it lines up with the word it qualifies.
    // ------------------------------------------------------------------------
    logic            r_stall;
    logic            r_clear;
    logic [XLEN-1:0] r_rd_old;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_stall  <= 1'b0;
            r_clear  <= 1'b1;
            r_rd_old <= CLEAR_VALUE;
        end else begin
            r_stall  <= ~en;
            r_clear  <= en & clear;
            r_rd_old <= RD;
        end
    end

    always_comb begin
        RD = r_rd_raw;
        if (r_stall) begin
            RD = r_rd_old;
        end else if (r_clear) begin
            RD = CLEAR_VALUE;
        end
    end

    // ------------------------------------------------------------------------
    // ID-stage PC and valid flag
    // ------------------------------------------------------------------------
    logic [XLEN-1:0] r_pcd;
    logic            r_valid;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pcd   <= '0;
            r_valid <= 1'b0;
        end else if (en) begin
            r_pcd   <= clear ? '0 : PCF;
            r_valid <= ~clear;
        end
    end

    assign PCD    = r_pcd;
    assign ValidD = r_valid;

`ifdef IDSEG_PERF_CNT_EN
    // ------------------------------------------------------------------------
    // Performance counters (free-running, wrap at 2^32)
    // ------------------------------------------------------------------------
    logic [31:0] r_stall_cnt;
    logic [31:0] r_flush_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if (!en) begin
                r_stall_cnt <= r_stall_cnt + 32'd1;
            end
            if (en && clear) begin
                r_flush_cnt <= r_flush_cnt + 32'd1;
            end
        end
    end

    assign StallCnt = r_stall_cnt;
    assign FlushCnt = r_flush_cnt;
`endif

endmodule

`default_nettype wire

// File: tb/tb_id_seg_reg_param.sv
// ============================================================================
// Module   : tb_id_seg_reg_param
// Purpose  : Self-checking bench for id_seg_reg_param. Directed scenarios
//            followed by randomized traffic, all compared every cycle with a
//            behavioural model of the segment register and its memory.
// Options  : honours IDSEG_PERF_CNT_EN for the counter outputs.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_id_seg_reg_param;

    localparam logic [31:0] c_CLR = 32'h00000013;

    logic        clk = 1'b0;
    logic        rst, clear, en;
    logic [31:0] A, RD, A2, WD2, RD2, PCF, PCD;
    logic [3:0]  WE2;
    logic        ValidD;
`ifdef IDSEG_PERF_CNT_EN
    logic [31:0] StallCnt, FlushCnt;
`endif

    id_seg_reg_param dut (
        .clk    (clk),
        .rst    (rst),
        .clear  (clear),
        .en     (en),
        .A      (A),
        .RD     (RD),
        .A2     (A2),
        .WD2    (WD2),
        .WE2    (WE2),
        .RD2    (RD2),
        .PCF    (PCF),
        .PCD    (PCD),
        .ValidD (ValidD)
`ifdef IDSEG_PERF_CNT_EN
        ,
        .StallCnt (StallCnt),
        .FlushCnt (FlushCnt)
`endif
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // ------------------------------------------------------------------------
    // Reference model: a word array plus the architectural view of the stage.
    // ------------------------------------------------------------------------
    logic [31:0] m_mem [4096];
    logic [31:0] m_rd, m_rd2, m_pcd;
    logic        m_valid;
    logic [31:0] m_stalls, m_flushes;

    task automatic cycle();
        int          ia, ib;
        logic [31:0] old_a, old_b;
        @(posedge clk);
        ia    = int'(A[13:2]);
        ib    = int'(A2[13:2]);
        old_a = m_mem[ia];
        old_b = m_mem[ib];
        if (rst) begin
            m_rd = c_CLR; m_pcd = '0; m_valid = 1'b0;
            m_stalls = '0; m_flushes = '0;
        end else if (!en) begin
            m_stalls++;                       // everything visible holds
        end else if (clear) begin
            m_rd = c_CLR; m_pcd = '0; m_valid = 1'b0;
            m_flushes++;
        end else begin
            m_rd = old_a; m_pcd = PCF; m_valid = 1'b1;
        end
        m_rd2 = old_b;
        for (int b = 0; b < 4; b++)
            if (WE2[b]) m_mem[ib][b*8 +: 8] = WD2[b*8 +: 8];
        #1;
        if (!$isunknown(m_rd))  check("rd", RD, m_rd);
        if (!$isunknown(m_rd2)) check("rd2", RD2, m_rd2);
        check("pcd", PCD, m_pcd);
        check("valid", {31'd0, ValidD}, {31'd0, m_valid});
`ifdef IDSEG_PERF_CNT_EN
        check("stall_cnt", StallCnt, m_stalls);
        check("flush_cnt", FlushCnt, m_flushes);
`endif
    endtask

    // Random byte address inside the preloaded 32-word window, with random
    // byte offset and random high bits to exercise address wrapping.
    function automatic logic [31:0] rand_addr();
        logic [31:0] r;
        r = $urandom;
        return (r & ~32'h0000_3FFC) | (32'($urandom_range(0, 31)) << 2);
    endfunction

    initial begin
        for (int i = 0; i < 4096; i++) m_mem[i] = 'x;
        m_rd = 'x; m_rd2 = 'x; m_pcd = '0; m_valid = 1'b0;
        m_stalls = '0; m_flushes = '0;
        rst = 1'b1; en = 1'b1; clear = 1'b0;
        A = '0; PCF = '0; A2 = '0; WD2 = '0; WE2 = '0;

        // Preload words 0..31 through the debug port while held in reset.
        for (int i = 0; i < 32; i++) begin
            A2  = 32'(i) << 2;
            WD2 = (i == 0) ? 32'h00500093 : (i == 4) ? 32'h11223344 : $urandom;
            WE2 = 4'hF;
            cycle();
        end
        WE2 = '0; A2 = '0;
        cycle();
        cycle();
        check("rst_rd", RD, 32'h00000013);
        check("rst_pcd", PCD, 32'h0);
        check("rst_valid", {31'd0, ValidD}, 32'd0);

        // Normal flow.
        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            A = 32'(k) * 4; PCF = A;
            cycle();
        end
        check("flow_rd0", RD, m_mem[2]);
        check("flow_pcd", PCD, 32'h8);

        // Three-cycle stall with the fetch address moving, then release.
        en = 1'b0; A = 32'h40; PCF = 32'h40;
        repeat (3) cycle();
        check("stall_pcd", PCD, 32'h8);
        en = 1'b1;
        cycle();
        check("unstall_rd", RD, m_mem[16]);

        // Flush honoured, then flush during stall ignored.
        clear = 1'b1; PCF = 32'h8; A = 32'h8;
        cycle();
        check("flush_rd", RD, c_CLR);
        check("flush_valid", {31'd0, ValidD}, 32'd0);
        en = 1'b0; PCF = 32'h20;
        cycle();
        check("stall_clear_pcd", PCD, 32'h0);
        en = 1'b1; clear = 1'b0; PCF = 32'h24; A = 32'h24;
        cycle();
        check("post_flush_valid", {31'd0, ValidD}, 32'd1);

        // Partial debug write with a same-word fetch in the same cycle.
        A2 = 32'h10; WD2 = 32'hAABBCCDD; WE2 = 4'b0101; A = 32'h10; PCF = 32'h10;
        cycle();
        check("same_word_rd", RD, 32'h11223344);
        WE2 = '0;
        cycle();
        check("rd2_merge", RD2, 32'h11BB33DD);

        // Counter scenario: reset, five stalls, two flushes.
        rst = 1'b1;
        cycle();
        rst = 1'b0; en = 1'b0;
        repeat (5) cycle();
        en = 1'b1; clear = 1'b1;
        repeat (2) cycle();
        clear = 1'b0;
        cycle();
`ifdef IDSEG_PERF_CNT_EN
        check("stall_cnt_5", StallCnt, 32'd5);
        check("flush_cnt_2", FlushCnt, 32'd2);
        rst = 1'b1;
        cycle();
        check("stall_cnt_rst", StallCnt, 32'd0);
        rst = 1'b0;
`endif

        // Randomized traffic.
        for (int n = 0; n < 600; n++) begin
            rst   = ($urandom_range(0, 49) == 0);
            en    = ($urandom_range(0, 3) != 0);
            clear = ($urandom_range(0, 4) == 0);
            A     = rand_addr();
            PCF   = $urandom;
            A2    = rand_addr();
            WD2   = $urandom;
            WE2   = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'h0;
            cycle();
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
